alu: RTL and testbench

Registered integer ALU for the RV32I datapath. Computes one of eleven logic, arithmetic, compare or shift operations on two `width`-bit operands selected by a 4-bit `alu_control` code. Result, zero flag and signed-overflow flag are registered on the rising clock edge. Sits in the execute stage and is fed by the decoder's ALU-control output.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_shifter.sv | 28 ++
 rtl/alu.sv | 89 ++++++++
 tb/tb_alu.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   ALU_* : 4-bit operation codes driven on alu_control by the decoder.
//   SHIFT_*: 2-bit mode codes understood by alu_shifter.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  // Shift modes line up with alu_control[1:0] of the three shift opcodes.
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for SLL / SRL / SRA.
// Ports:
//   a      in  width           value to shift
//   shamt  in  log2(width)     shift amount
//   mode   in  2               SHIFT_SLL / SHIFT_SRL / SHIFT_SRA (other: 0)
//   y      out width           shifted value
module alu_shifter
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0]         a,
  input  logic [$clog2(width)-1:0] shamt,
  input  logic [1:0]               mode,
  output logic [width-1:0]         y
);

  always_comb begin
    y = '0;
    case (mode)
      SHIFT_SLL: y = a << shamt;
      SHIFT_SRL: y = a >> shamt;
      SHIFT_SRA: y = $unsigned($signed(a) >>> shamt);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: registered RV32I integer ALU, one-cycle latency, full throughput.
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      synchronous active-high reset
//   a, b         in  width  operands (low log2(width) bits of b = shift amount)
//   alu_control  in  4      operation select (alu_pkg::ALU_*)
//   result       out width  registered result
//   zero         out 1      registered, 1 when result is all zeros
//   overflow     out 1      registered signed overflow for ADD/SUB only
module alu
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [width-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(width);

  logic [width-1:0] sum;
  logic [width-1:0] diff;
  logic [width-1:0] shift_y;
  logic             lt_signed;
  logic             lt_unsigned;
  logic             ovf_add;
  logic             ovf_sub;
  logic [width-1:0] result_next;
  logic             overflow_next;

  assign sum  = a + b;
  assign diff = a - b;

  // True signed compare, independent of the subtraction sign bit.
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  assign ovf_add = (a[width-1] == b[width-1]) && (sum[width-1]  != a[width-1]);
  assign ovf_sub = (a[width-1] != b[width-1]) && (diff[width-1] != a[width-1]);

  alu_shifter #(.width(width)) u_shifter (
    .a     (a),
    .shamt (b[SHW-1:0]),
    .mode  (alu_control[1:0]),
    .y     (shift_y)
  );

  always_comb begin
    result_next   = '0;
    overflow_next = 1'b0;
    case (alu_control)
      ALU_AND:  result_next = a & b;
      ALU_OR:   result_next = a | b;
      ALU_ADD: begin
        result_next   = sum;
        overflow_next = ovf_add;
      end
      ALU_SUB: begin
        result_next   = diff;
        overflow_next = ovf_sub;
      end
      ALU_SLT:  result_next = {{(width-1){1'b0}}, lt_signed};
      ALU_SLTU: result_next = {{(width-1){1'b0}}, lt_unsigned};
      ALU_NOR:  result_next = ~(a | b);
      ALU_XOR:  result_next = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: result_next = shift_y;
      default:  result_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      result   <= result_next;
      zero     <= (result_next == '0);
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu (width = 32).
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int n_vec;
  int n_miss;

  alu #(.width(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Drive one operation, clock it in, then check all three outputs.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_res,
                       input logic exp_zero, input logic exp_ovf);
    alu_control = op;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_zero});
    check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    alu_control = ALU_AND;
    repeat (2) @(posedge clk);
    #1;
    check("rst.result", result, 32'h0);
    check("rst.zero", {31'b0, zero}, 32'h1);
    check("rst.ovf", {31'b0, overflow}, 32'h0);
    rst = 1'b0;

    // logic
    apply("and", ALU_AND, 32'h0000000F, 32'h00000003, 32'h00000003, 1'b0, 1'b0);
    apply("or",  ALU_OR,  32'h0000000F, 32'h00000003, 32'h0000000F, 1'b0, 1'b0);
    apply("nor", ALU_NOR, 32'h0000000F, 32'h00000003, 32'hFFFFFFF0, 1'b0, 1'b0);
    apply("xor", ALU_XOR, 32'h0000000F, 32'h00000003, 32'h0000000C, 1'b0, 1'b0);

    // arithmetic
    apply("add",      ALU_ADD, 32'h0000000F, 32'h00000003, 32'h00000012, 1'b0, 1'b0);
    apply("sub",      ALU_SUB, 32'h0000000F, 32'h00000003, 32'h0000000C, 1'b0, 1'b0);
    apply("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    apply("add_nov",  ALU_ADD, 32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 1'b0);
    apply("add_neg",  ALU_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    apply("sub_ovf",  ALU_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
    apply("sub_nov",  ALU_SUB, 32'h80000000, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0);
    apply("sub_ovf2", ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);

    // compare
    apply("slt_pos",  ALU_SLT,  32'h00000003, 32'h0000000F, 32'h00000001, 1'b0, 1'b0);
    apply("slt_neg",  ALU_SLT,  32'hFFFFFFFC, 32'h00000003, 32'h00000001, 1'b0, 1'b0);
    apply("slt_ovf",  ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    apply("slt_ovf2", ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    apply("sltu_big", ALU_SLTU, 32'hFFFFFFFF, 32'h0000000F, 32'h00000000, 1'b1, 1'b0);
    apply("sltu_gt",  ALU_SLTU, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0);
    apply("sltu_lt",  ALU_SLTU, 32'h0000000F, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);

    // shifts
    apply("sll",      ALU_SLL, 32'h0000000F, 32'h00000002, 32'h0000003C, 1'b0, 1'b0);
    apply("srl",      ALU_SRL, 32'h0000000F, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
    apply("sra",      ALU_SRA, 32'hFFFFFFF0, 32'h00000002, 32'hFFFFFFFC, 1'b0, 1'b0);
    apply("sll_wrap", ALU_SLL, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0);
    apply("srl_msb",  ALU_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0);
    apply("sra_msb",  ALU_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0);
    apply("sra_pos",  ALU_SRA, 32'h70000000, 32'h00000004, 32'h07000000, 1'b0, 1'b0);
    apply("sra_zero", ALU_SRA, 32'h8000000F, 32'hFFFFFFE0, 32'h8000000F, 1'b0, 1'b0);

    // zero flag and undefined opcodes
    apply("sub_zero", ALU_SUB, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    apply("op_1111",  4'b1111, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    apply("op_1011",  4'b1011, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 1'b1, 1'b0);
    apply("op_1100",  4'b1100, 32'h12345678, 32'h00000004, 32'h00000000, 1'b1, 1'b0);

    // outputs hold between edges
    apply("hold_pre", ALU_OR, 32'h00F00000, 32'h0000000A, 32'h00F0000A, 1'b0, 1'b0);
    alu_control = ALU_ADD;
    a = 32'h7FFFFFFF;
    b = 32'h00000001;
    #3;
    check("hold.result", result, 32'h00F0000A);
    check("hold.ovf", {31'b0, overflow}, 32'h0);

    // reset wins over a pending overflowing ADD
    rst = 1'b1;
    apply("rst_add", ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    rst = 1'b0;
    apply("post_rst", ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
